// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;
    localparam int BYTE_W        = 8;
    localparam int BUSY_WAIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping around.
// Zero latency; no state, the caller owns last-grant tracking.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         index
);
    logic w_found;

    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    grant[i] = 1'b1;
                    index    = 2'(i);
                    w_found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NUM_REQ byte requesters onto one UART transmitter; valid->send_en is 2 cycles.
// Backpressure: req_ready only in IDLE with the transmitter free; bytes held by requesters until granted.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int BUSY_WAIT = BUSY_WAIT_DEF
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      send_en,
    output logic [BYTE_W-1:0]         send_data,
    input  logic                      tx_busy,
    output logic [1:0]                grant_id,
    output logic                      err_timeout
);
    localparam int CW = $clog2(BUSY_WAIT + 1);

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [1:0]          r_last;
    logic [BYTE_W-1:0]   r_send_data, w_byte;
    logic [1:0]          r_grant_id, w_idx;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_accept, w_cnt_clr, w_cnt_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant),
        .index (w_idx)
    );

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_byte = req_data[BYTE_W*i +: BYTE_W];
        end
    end

    // Grant is gated by reset so req_ready stays low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        send_en     = 1'b0;
        err_timeout = 1'b0;
        w_accept    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!sys_rst && !tx_busy && (|req_valid)) begin
                    req_ready   = w_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  w_state_nxt = ST_START;
            ST_START: begin
                send_en     = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt == CW'(BUSY_WAIT - 1)) begin
                    err_timeout = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_last      <= 2'(NUM_REQ - 1);
            r_send_data <= '0;
            r_grant_id  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
            if (w_accept) begin
                r_send_data <= w_byte;
                r_grant_id  <= w_idx;
                r_last      <= w_idx;
            end
        end
    end

    assign send_data = r_send_data;
    assign grant_id  = r_grant_id;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboarded bench for uart_tx_arb with a simple transmitter model.
module tb_uart_tx_arb;
    localparam int BW    = 16;
    localparam int FRAME = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        send_en;
    logic [7:0]  send_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        err_timeout;

    logic        foreign, model_en, m_busy;
    int          m_cnt;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;
    exp_t sb_q[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_send = 0, n_err = 0, t_send = 0, t_err = 0;
    int ta, acc, sends_before;

    uart_tx_arb #(.NUM_REQ(2), .BUSY_WAIT(BW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .send_en     (send_en),
        .send_data   (send_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Transmitter: busy rises the cycle after send_en and lasts FRAME cycles.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt == FRAME - 1) m_busy <= 1'b0;
            m_cnt <= m_cnt + 1;
        end else if (send_en && model_en) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
        end
    end
    assign tx_busy = m_busy | foreign;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic [1:0] id);
        sb_q.push_back({d, id});
    endtask

    always @(negedge sys_clk) begin
        if (send_en) begin
            exp_t e;
            n_send++;
            t_send = cyc;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_send", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("send_data", send_data, e.data);
                check("grant_id", grant_id, e.id);
            end
        end
        if (err_timeout) begin
            n_err++;
            t_err = cyc;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 2'b00);
        check({tag, "_send_en"}, send_en, 1'b0);
        check({tag, "_send_data"}, send_data, 8'h00);
        check({tag, "_grant_id"}, grant_id, 2'd0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1; req_valid = '0; req_data = '0; foreign = 1'b0; model_en = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Single request from port 0
        @(negedge sys_clk);
        req_data = {8'h5A, 8'hA5}; req_valid = 2'b01;
        #1;
        check("t1_ready", req_ready, 2'b01);
        ta = cyc;
        expect_byte(8'hA5, 2'd0);
        @(negedge sys_clk);
        req_valid = '0;
        #1;
        check("t1_ready_low", req_ready, 2'b00);
        check("t1_load_no_send", send_en, 1'b0);
        repeat (20) @(negedge sys_clk);
        check("t1_latency", t_send - ta, 2);

        // Foreign traffic holds off the grant
        foreign = 1'b1; req_data = {8'h00, 8'h3C}; req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            #1;
            check("fb_ready_low", req_ready, 2'b00);
        end
        @(negedge sys_clk);
        foreign = 1'b0;
        #1;
        check("fb_grant", req_ready, 2'b01);
        expect_byte(8'h3C, 2'd0);
        @(negedge sys_clk);
        req_valid = '0;
        repeat (20) @(negedge sys_clk);

        // Transmitter never answers
        model_en = 1'b0;
        @(negedge sys_clk);
        req_data = {8'h77, 8'h00}; req_valid = 2'b10;
        #1;
        check("to_ready", req_ready, 2'b10);
        expect_byte(8'h77, 2'd1);
        @(negedge sys_clk);
        req_valid = '0;
        for (int i = 0; i < 60 && n_err == 0; i++) begin
            @(negedge sys_clk);
            #1;
        end
        check("to_seen", n_err, 1);
        check("to_delay", t_err - t_send, BW);
        @(negedge sys_clk);
        #1;
        check("to_width", n_err, 1);
        model_en = 1'b1;
        req_data = {8'h00, 8'h99}; req_valid = 2'b01;
        #1;
        check("to_recover_ready", req_ready, 2'b01);
        expect_byte(8'h99, 2'd0);
        @(negedge sys_clk);
        req_valid = '0;
        repeat (20) @(negedge sys_clk);
        check("to_no_extra_err", n_err, 1);

        // Reset during WAIT_DONE, then fairness from a fresh last_grant
        req_data = {8'h42, 8'h00}; req_valid = 2'b10;
        #1;
        check("rd_ready", req_ready, 2'b10);
        expect_byte(8'h42, 2'd1);
        @(negedge sys_clk);
        req_valid = '0;
        repeat (5) @(negedge sys_clk);
        check("rd_busy_before_rst", tx_busy, 1'b1);
        sends_before = n_send;
        sys_rst = 1'b1; req_valid = 2'b11; req_data = {8'h22, 8'h11};
        @(negedge sys_clk);
        #1;
        check_reset_outputs("rd");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check("rd_no_send", n_send, sends_before);
        check("rd_first_grant", req_ready, 2'b01);
        expect_byte(8'h11, 2'd0);
        expect_byte(8'h22, 2'd1);
        expect_byte(8'h11, 2'd0);
        expect_byte(8'h22, 2'd1);
        acc = 0;
        for (int i = 0; i < 200 && acc < 4; i++) begin
            if (i > 0) begin
                @(negedge sys_clk);
                #1;
            end
            if (|(req_valid & req_ready)) begin
                acc++;
                check("fair_onehot", $countones(req_ready), 1);
            end
        end
        check("fair_accepts", acc, 4);
        @(negedge sys_clk);
        req_valid = '0;
        repeat (25) @(negedge sys_clk);
        check("fair_sends", n_send, sends_before + 4);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requester ports (2..4).
REQ-002 The block SHALL have parameter BUSY_WAIT, default 16, max cycles from the send_en pulse to tx_busy rising.
REQ-003 The block SHALL have port sys_clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port sys_rst, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ, per-requester byte-valid.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ, per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ, per-requester accept; transfer occurs when valid and ready are both high.
REQ-008 The block SHALL have port send_en, output, 1, start pulse to the UART transmitter.
REQ-009 The block SHALL have port send_data, output, 8, byte to the UART transmitter.
REQ-010 The block SHALL have port tx_busy, input, 1, transmitter busy flag.
REQ-011 The block SHALL have port grant_id, output, 2, index of the requester owning the current byte.
REQ-012 The block SHALL have port err_timeout, output, 1, one-cycle pulse when tx_busy fails to rise within BUSY_WAIT.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: when tx_busy=0 and any req_valid=1, the block SHALL pick a winner by round-robin, starting after last_grant, assert req_ready[winner] combinationally that cycle, capture req_data into send_data and the index into grant_id, and go to LOAD.
REQ-015 req_ready SHALL be 0 for every port in every state except IDLE, and at most one bit SHALL be high.
REQ-016 LOAD SHALL hold send_en=0 for one cycle, then go to START. This guarantees a low phase before each rising edge.
REQ-017 START SHALL drive send_en=1 for exactly one cycle, clear the wait counter, and go to WAIT_BUSY.
REQ-018 WAIT_BUSY: tx_busy=1 SHALL go to WAIT_DONE. Otherwise the counter increments, and when counter reaches BUSY_WAIT-1 the block SHALL pulse err_timeout, drop the byte and go to IDLE.
REQ-019 WAIT_DONE SHALL go to IDLE on the first cycle tx_busy=0.
REQ-020 last_grant SHALL update to the winner on acceptance, so a requester that keeps valid high cannot win twice in a row while another is valid.
REQ-021 send_data and grant_id SHALL hold their values from LOAD until the next acceptance.
REQ-022 If tx_busy=1 in IDLE (foreign traffic), no grant SHALL be issued.
REQ-023 A req_valid that deasserts before being granted SHALL NOT be remembered.
REQ-024 Minimum throughput SHALL be one byte per (UART frame + 4) cycles. Latency from valid (idle bus) to the send_en pulse SHALL be 2 cycles.

Reset
REQ-025 While sys_rst=1, the state SHALL be IDLE, send_en=0, send_data=8'h00, grant_id=0, err_timeout=0, req_ready=0, last_grant=NUM_REQ-1 (port 0 wins first), and counter=0.
REQ-026 Reset asserted mid-transfer SHALL abandon the byte without emitting send_en. After release, operation SHALL resume from IDLE on the first clock edge.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state encoding, the default BUSY_WAIT, and the byte width constant 8.
REQ-028 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last; output one-hot grant and index); the FSM and the counter SHALL stay in uart_tx_arb.

Verification
REQ-029 Single request: req_valid=01, req_data[7:0]=8'hA5, transmitter model raises tx_busy 1 cycle after send_en -> req_ready=01 for 1 cycle, send_en pulse 2 cycles later, send_data=A5, grant_id=0.
REQ-030 Fairness: both ports held valid (port0=8'h11, port1=8'h22) for 4 bytes -> send order 11,22,11,22; grant_id alternates 0,1,0,1.
REQ-031 Timeout: tx_busy tied 0 after a grant -> err_timeout pulses exactly BUSY_WAIT cycles after the send_en pulse; FSM returns to IDLE; next request is served normally.
REQ-032 Foreign busy: tx_busy=1 while req_valid=01 -> req_ready stays 0 until tx_busy=0, then the grant follows in the same cycle.
REQ-033 Reset mid-WAIT_DONE: sys_rst pulsed for 2 cycles -> all outputs return to reset values; no extra send_en; port 0 wins the first post-reset grant.
